// File: rtl/vec_datapath_if.sv
// Operand/result streaming port of the vector datapath engine, plus job control and status.
interface vec_datapath_if #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 9
);
  logic             start;
  logic [1:0]       mode;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_data;
  logic [WIDTH-1:0] b_data;
  logic [WIDTH-1:0] c_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             ovf;

  modport slave (
    input  start, mode, len, in_valid, a_data, b_data, c_data, out_ready,
    output in_ready, out_valid, result, busy, done, ovf
  );

  modport master (
    output start, mode, len, in_valid, a_data, b_data, c_data, out_ready,
    input  in_ready, out_valid, result, busy, done, ovf
  );
endinterface

// File: rtl/vec_datapath_engine.sv
// Streams len (a,b,c) triples through a 3-stage pipeline computing a+K*b or c*(a+K*b).
//
// state | meaning
// IDLE  | waiting for start; mode/len latched here
// RUN   | accepting operands until len inputs taken
// DRAIN | all inputs taken, emptying the pipeline
// DONE  | one-cycle job-complete pulse
module vec_datapath_engine #(
  parameter int WIDTH   = 32,
  parameter int MAX_LEN = 256,
  parameter int K_LO    = 2,
  parameter int K_HI    = 5,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input logic           clk,
  input logic           rst,
  vec_datapath_if.slave bus
);
  localparam int BKW = WIDTH + 4;
  localparam int SW  = WIDTH + 5;
  localparam int PW  = 2 * WIDTH + 5;
  localparam logic [3:0]       K_LO4     = 4'(K_LO);
  localparam logic [3:0]       K_HI4     = 4'(K_HI);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q;
  logic [LEN_W-1:0] len_q, len_clamp, in_cnt, out_cnt;
  logic             ovf_q;
  logic             stall, accept, emit, last_in, last_out;
  logic [3:0]       k_sel;

  logic             s1_v, s2_v, s3_v;
  logic [WIDTH-1:0] s1_a, s1_c, s2_c;
  logic [BKW-1:0]   s1_bk;
  logic [SW-1:0]    s2_sum;
  logic [PW-1:0]    full;
  logic [WIDTH-1:0] s3_result;
  logic             s3_big;

  assign len_clamp = (bus.len > MAX_LEN_L) ? MAX_LEN_L : bus.len;
  assign stall     = s3_v & ~bus.out_ready;
  assign accept    = bus.in_valid & bus.in_ready;
  assign emit      = s3_v & bus.out_ready;
  assign last_in   = accept & ((in_cnt + LEN_W'(1)) == len_q);
  assign last_out  = emit & ((out_cnt + LEN_W'(1)) == len_q);
  // Modes 01 and 10 use the high coefficient.
  assign k_sel     = (mode_q[1] ^ mode_q[0]) ? K_HI4 : K_LO4;

  assign bus.out_valid = s3_v;
  assign bus.result    = s3_result;
  assign bus.ovf       = ovf_q;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    bus.in_ready = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = (len_clamp == '0) ? DONE : RUN;
      end
      RUN: begin
        bus.busy     = 1'b1;
        bus.in_ready = (in_cnt < len_q) & ~stall;
        if (last_in) state_d = DRAIN;
      end
      DRAIN: begin
        bus.busy = 1'b1;
        if (last_out) state_d = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q  <= '0;
      len_q   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      ovf_q   <= 1'b0;
    end else if (state_q == IDLE && bus.start) begin
      mode_q  <= bus.mode;
      len_q   <= len_clamp;
      in_cnt  <= '0;
      out_cnt <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept) in_cnt <= in_cnt + LEN_W'(1);
      if (emit) begin
        out_cnt <= out_cnt + LEN_W'(1);
        if (s3_big) ovf_q <= 1'b1;
      end
    end
  end

  // Full-precision value of the element entering S3; only the low WIDTH bits are kept.
  assign full = mode_q[1] ? (PW'(s2_c) * PW'(s2_sum)) : PW'(s2_sum);

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      s3_v      <= 1'b0;
      s1_a      <= '0;
      s1_c      <= '0;
      s1_bk     <= '0;
      s2_c      <= '0;
      s2_sum    <= '0;
      s3_result <= '0;
      s3_big    <= 1'b0;
    end else if (!stall) begin
      s1_v      <= accept;
      s1_a      <= bus.a_data;
      s1_c      <= bus.c_data;
      s1_bk     <= BKW'(bus.b_data) * BKW'(k_sel);
      s2_v      <= s1_v;
      s2_c      <= s1_c;
      s2_sum    <= SW'(s1_a) + SW'(s1_bk);
      s3_v      <= s2_v;
      s3_result <= full[WIDTH-1:0];
      s3_big    <= |full[PW-1:WIDTH];
    end
  end
endmodule

// File: tb/tb_vec_datapath_engine.sv
// Directed bench for vec_datapath_engine: modes, backpressure, len=0, overflow, reset abort.
module tb_vec_datapath_engine;
  localparam int WIDTH = 32;
  localparam int LEN_W = 9;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] va [8];
  logic [31:0] vb [8];
  logic [31:0] vc [8];
  logic [31:0] vexp [8];
  logic [15:0] lfsr = 16'hACE1;

  vec_datapath_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  vec_datapath_engine #(.WIDTH(WIDTH), .MAX_LEN(256), .K_LO(2), .K_HI(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic set_vec(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] e);
    va[i] = a; vb[i] = b; vc[i] = c; vexp[i] = e;
  endtask

  // Leaves the bench 1 time unit after the edge that sampled start (cycle 1).
  task automatic start_job(input logic [1:0] m, input logic [LEN_W-1:0] l);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.len   = l;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.mode  = ~m;
    bus.len   = '0;
    check("start_ovf_clear", bus.ovf, 0);
    if (l != '0) begin
      check("start_busy", bus.busy, 1);
      check("start_in_ready", bus.in_ready, 1);
    end
  endtask

  task automatic run_job(input logic [1:0] m, input int n, input bit bp, input bit poke,
                         input logic exp_ovf);
    int cyc = 0;
    int in_idx = 0;
    int out_idx = 0;
    int done_cnt = 0;
    int done_cyc = -10;
    int last_out_cyc = -10;
    int first_acc = -1;
    int first_ov = -1;
    bit acc_in, acc_out;
    start_job(m, n[LEN_W-1:0]);
    while (cyc < 200 && !(done_cnt > 0 && cyc > done_cyc + 2)) begin
      cyc++;
      bus.in_valid = (in_idx < n);
      bus.a_data   = va[in_idx % 8];
      bus.b_data   = vb[in_idx % 8];
      bus.c_data   = vc[in_idx % 8];
      if (bp) begin
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        bus.out_ready = lfsr[0];
      end else begin
        bus.out_ready = 1'b1;
      end
      bus.start = poke && in_idx >= 1 && in_idx < 3;
      #1;
      if (bus.out_valid && !bus.out_ready) check("stall_in_ready", bus.in_ready, 0);
      if (bus.out_valid && first_ov < 0) first_ov = cyc;
      acc_in  = bus.in_valid && bus.in_ready;
      acc_out = bus.out_valid && bus.out_ready;
      if (acc_in && first_acc < 0) first_acc = cyc;
      if (bus.out_valid) begin
        if (out_idx >= n) check("extra_output", out_idx, n);
        else check("result", bus.result, vexp[out_idx]);
      end
      if (acc_out) begin
        out_idx++;
        last_out_cyc = cyc;
      end
      if (acc_in) in_idx++;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_busy", bus.busy, 0);
        check("done_timing", cyc, last_out_cyc + 1);
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    check("job_timeout", cyc < 200, 1);
    check("out_count", out_idx, n);
    check("done_count", done_cnt, 1);
    check("latency", first_ov - first_acc, 3);
    check("ovf", bus.ovf, exp_ovf);
    check("idle_busy", bus.busy, 0);
  endtask

  initial begin
    int dn;
    bus.start = 1'b0; bus.mode = '0; bus.len = '0; bus.in_valid = 1'b0;
    bus.a_data = '0; bus.b_data = '0; bus.c_data = '0; bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ovf", bus.ovf, 0);
    @(negedge clk);
    rst = 1'b1;

    // mode 00: a + 2b, c must be ignored
    set_vec(0, 1, 2, 9, 5); set_vec(1, 2, 2, 9, 6);
    set_vec(2, 3, 2, 9, 7); set_vec(3, 4, 2, 9, 8);
    run_job(2'b00, 4, 0, 0, 0);

    // mode 10: c*(a+5b); mode 11: c*(a+2b)
    set_vec(0, 1, 2, 3, 33); set_vec(1, 0, 1, 7, 35);
    run_job(2'b10, 2, 0, 0, 0);
    set_vec(0, 1, 2, 3, 15); set_vec(1, 0, 1, 7, 14);
    run_job(2'b11, 2, 0, 0, 0);

    // mode 01 under random backpressure, with start poked during RUN
    for (int i = 0; i < 8; i++) set_vec(i, 32'(i * 10), 32'(i + 1), 32'd3, 32'(i * 10 + 5 * (i + 1)));
    run_job(2'b01, 8, 1, 1, 0);

    // len = 0
    start_job(2'b00, '0);
    check("len0_done", bus.done, 1);
    check("len0_busy", bus.busy, 0);
    check("len0_in_ready", bus.in_ready, 0);
    check("len0_out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
    check("len0_done_pulse", bus.done, 0);
    check("len0_busy_after", bus.busy, 0);

    // overflow: 0xFFFFFFFF + 2*1 wraps to 1
    set_vec(0, 32'hFFFF_FFFF, 1, 0, 1);
    run_job(2'b00, 1, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    check("ovf_held", bus.ovf, 1);

    // reset with three elements in flight
    set_vec(0, 3, 4, 0, 11);
    start_job(2'b01, 9'd5);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.a_data = 32'(i); bus.b_data = 32'd1; bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    check("inflight_out_valid", bus.out_valid, 1);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("abort_in_ready", bus.in_ready, 0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_result", bus.result, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_ovf", bus.ovf, 0);
    dn = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.done) dn++;
    end
    check("abort_no_done", dn, 0);
    run_job(2'b00, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
